// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: synchronises and filters the pins, deserialises
// 11-bit frames and folds the F0 (break) and E0 (extended) prefixes into flags
// that travel with the next non-prefix scan code.
module ps2_scan_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       is_break_code,
  output logic       is_extended,
  output logic       code_valid,
  output logic       frame_error
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          fall;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tmo_cnt;
  logic          brk_pend, ext_pend;

  // Two-flop synchronisers; idle level of both pins is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_s2 == clk_filt) begin
      flt_cnt  <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_s2;
      flt_cnt  <= '0;
    end else begin
      flt_cnt  <= flt_cnt + 1'b1;
    end
  end

  // A fall is the cycle in which the filtered clock is about to go 1->0.
  assign fall = clk_filt & ~clk_s2 & (flt_cnt == FW'(FILTER_LEN - 1));

  // Frame FSM with timeout, prefix tracking and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      par           <= 1'b0;
      tmo_cnt       <= '0;
      brk_pend      <= 1'b0;
      ext_pend      <= 1'b0;
      scan_code     <= '0;
      is_break_code <= 1'b0;
      is_extended   <= 1'b0;
      code_valid    <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
      // A fall in the same cycle wins over an expiring timeout.
      if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state       <= IDLE;
        tmo_cnt     <= '0;
        frame_error <= 1'b1;
        brk_pend    <= 1'b0;
        ext_pend    <= 1'b0;
      end else begin
        if (state == IDLE || fall) tmo_cnt <= '0;
        else                       tmo_cnt <= tmo_cnt + 1'b1;
        if (fall) begin
          case (state)
            IDLE: begin
              if (!data_s2) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shreg[bit_cnt] <= data_s2;
              if (bit_cnt == 3'd7) state <= PARITY;
              else                 bit_cnt <= bit_cnt + 1'b1;
            end
            PARITY: begin
              par   <= data_s2;
              state <= STOP;
            end
            STOP: begin
              state <= IDLE;
              if (data_s2 && (^{shreg, par})) begin
                if (shreg == 8'hF0) begin
                  brk_pend <= 1'b1;
                end else if (shreg == 8'hE0) begin
                  ext_pend <= 1'b1;
                end else begin
                  scan_code     <= shreg;
                  is_break_code <= brk_pend;
                  is_extended   <= ext_pend;
                  code_valid    <= 1'b1;
                  brk_pend      <= 1'b0;
                  ext_pend      <= 1'b0;
                end
              end else begin
                frame_error <= 1'b1;
                brk_pend    <= 1'b0;
                ext_pend    <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Scoreboard bench for ps2_scan_receiver: frame driver plus prefix-folding
// reference model push expected events; a monitor pops them on every strobe.
module tb_ps2_scan_receiver;
  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       is_break_code, is_extended, code_valid, frame_error;

  ps2_scan_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_code(scan_code), .is_break_code(is_break_code), .is_extended(is_extended),
    .code_valid(code_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0, failures = 0;
  longint     cyc = 0, last_fall_cyc = 0, strobe_cyc = 0;
  logic       m_brk_p = 0, m_ext_p = 0, m_brk = 0, m_ext = 0;
  logic [7:0] m_code = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (code_valid || frame_error)) begin
      ev_t got, e;
      strobe_cyc = cyc;
      got = '{err: frame_error, code: scan_code, brk: is_break_code, ext: is_extended};
      checks++;
      if (code_valid && frame_error) begin
        failures++;
        $display("FAIL strobe_exclusive got cv=%b fe=%b want not both", code_valid, frame_error);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe got=%h want no strobe", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL event got err=%b code=%h brk=%b ext=%b want err=%b code=%h brk=%b ext=%b",
                   got.err, got.code, got.brk, got.ext, e.err, e.code, e.brk, e.ext);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference model: what a complete frame should produce at the output.
  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_q.push_back('{err: 1'b1, code: m_code, brk: m_brk, ext: m_ext});
      m_brk_p = 0; m_ext_p = 0;
    end else if (b == 8'hF0) begin
      m_brk_p = 1;
    end else if (b == 8'hE0) begin
      m_ext_p = 1;
    end else begin
      m_code = b; m_brk = m_brk_p; m_ext = m_ext_p;
      exp_q.push_back('{err: 1'b0, code: m_code, brk: m_brk, ext: m_ext});
      m_brk_p = 0; m_ext_p = 0;
    end
  endtask

  // Drive the first nbits bits of a frame; full frames also feed the model.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    if (nbits == 11) model_frame(b, !(bad_par || bad_stop));
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF / 2);
      if (glitch) begin
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
      end
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s got %0d pending events want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_scan_code"}, {24'd0, scan_code}, 32'h00);
    check({name, "_break"}, {31'd0, is_break_code}, 32'd0);
    check({name, "_ext"}, {31'd0, is_extended}, 32'd0);
    check({name, "_valid"}, {31'd0, code_valid}, 32'd0);
    check({name, "_error"}, {31'd0, frame_error}, 32'd0);
  endtask

  initial begin
    wait_cyc(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_cyc(20);

    // Plain code, break prefix, lone code, extended+break.
    send_frame(8'h1C, 0, 0, 0, 11); drain("plain", 200);
    send_frame(8'hF0, 0, 0, 0, 11);
    send_frame(8'h1C, 0, 0, 0, 11); drain("break", 200);
    send_frame(8'h1C, 0, 0, 0, 11); drain("lone", 200);
    send_frame(8'hE0, 0, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 0, 11);
    send_frame(8'h75, 0, 0, 0, 11); drain("ext_break", 200);

    // Bad parity after a break prefix, then a good code, then a bad stop.
    send_frame(8'hF0, 0, 0, 0, 11);
    send_frame(8'h1C, 1, 0, 0, 11); drain("bad_parity", 200);
    send_frame(8'h32, 0, 0, 0, 11); drain("after_error", 200);
    send_frame(8'h1C, 0, 1, 0, 11); drain("bad_stop", 200);

    // Sub-filter glitches between bits.
    send_frame(8'h1C, 0, 0, 1, 11); drain("glitch", 200);

    // Timeout: start plus four data bits, then silence.
    exp_q.push_back('{err: 1'b1, code: m_code, brk: m_brk, ext: m_ext});
    m_brk_p = 0; m_ext_p = 0;
    strobe_cyc = 0;
    send_frame(8'hA5, 0, 0, 0, 5);
    wait_cyc(3000);
    drain("timeout", 10);
    checks++;
    if (strobe_cyc - last_fall_cyc < 1995 || strobe_cyc - last_fall_cyc > 2030) begin
      failures++;
      $display("FAIL timeout_delay got=%0d want 1995..2030", strobe_cyc - last_fall_cyc);
    end
    send_frame(8'h1C, 0, 0, 0, 11); drain("post_timeout", 200);

    // Reset mid-frame with a break prefix pending.
    send_frame(8'hF0, 0, 0, 0, 11);
    send_frame(8'h55, 0, 0, 0, 4);
    rst = 1'b1;
    m_brk_p = 0; m_ext_p = 0; m_code = 8'h00; m_brk = 0; m_ext = 0;
    wait_cyc(3);
    check_reset_outputs("mid_reset");
    ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(20);
    send_frame(8'h1C, 0, 0, 0, 11); drain("post_reset", 200);

    // Randomised mix of prefixes, codes, corrupt frames and glitches.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      int sel;
      sel = $urandom_range(0, 5);
      b = (sel == 0) ? 8'hF0 : (sel == 1) ? 8'hE0 : 8'($urandom_range(0, 255));
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0, 11);
      drain("random", 200);
    end

    wait_cyc(100);
    drain("final", 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
